// File: rtl/ysyx_25020047_ifu.sv
// Instruction fetch unit: holds the PC, reads one 32-bit word per instruction, hands it to decode.
// Latency: npc_valid at t, request accepted at once, response in first WAIT cycle -> inst_valid at t+3.
// Backpressure: mem_req_valid holds until mem_req_ready; inst/pc/snpc/fault hold until inst_ready.
module ysyx_25020047_ifu #(
  parameter logic [31:0] RESET_PC   = 32'h8000_0000,
  parameter logic [31:0] FAULT_INST = 32'h0000_0000,
  parameter int          CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  output logic             mem_req_valid,
  input  logic             mem_req_ready,
  output logic [31:0]      mem_req_addr,
  input  logic             mem_rsp_valid,
  input  logic [31:0]      mem_rsp_data,
  input  logic             mem_rsp_err,
  output logic             inst_valid,
  input  logic             inst_ready,
  output logic [31:0]      inst,
  output logic [31:0]      pc,
  output logic [31:0]      snpc,
  output logic             fault,
  input  logic             npc_valid,
  input  logic [31:0]      dnpc,
  output logic [CNT_W-1:0] fetch_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_DELIVER,
    S_NEXT
  } state_t;

  state_t state;
  state_t state_nxt;

  logic misaligned;
  logic rsp_take;
  logic fault_take;
  logic inst_hs;
  logic npc_take;

  assign misaligned   = (pc[1:0] != 2'b00);
  assign mem_req_addr = pc;
  // A misaligned PC never reaches memory; the fault word is captured directly in FETCH.
  assign fault_take   = (state == S_FETCH) && misaligned;
  assign rsp_take     = (state == S_WAIT) && mem_rsp_valid;
  assign inst_hs      = inst_valid && inst_ready;
  assign npc_take     = (state == S_NEXT) && npc_valid;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and handshake outputs decoded from the registered state.
  always_comb begin
    state_nxt     = state;
    mem_req_valid = 1'b0;
    inst_valid    = 1'b0;
    case (state)
      S_IDLE: begin
        state_nxt = S_FETCH;
      end
      S_FETCH: begin
        if (misaligned) begin
          state_nxt = S_DELIVER;
        end else begin
          mem_req_valid = 1'b1;
          if (mem_req_ready) begin
            state_nxt = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (mem_rsp_valid) begin
          state_nxt = S_DELIVER;
        end
      end
      S_DELIVER: begin
        inst_valid = 1'b1;
        if (inst_ready) begin
          state_nxt = S_NEXT;
        end
      end
      S_NEXT: begin
        if (npc_valid) begin
          state_nxt = S_FETCH;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // PC/snpc load only when execute supplies the next PC.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc   <= RESET_PC;
      snpc <= RESET_PC + 32'd4;
    end else if (npc_take) begin
      pc   <= dnpc;
      snpc <= dnpc + 32'd4;
    end
  end

  // Instruction word and fault flag captured from the response or from a misaligned PC.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inst  <= 32'h0000_0000;
      fault <= 1'b0;
    end else if (fault_take) begin
      inst  <= FAULT_INST;
      fault <= 1'b1;
    end else if (rsp_take) begin
      inst  <= mem_rsp_err ? FAULT_INST : mem_rsp_data;
      fault <= mem_rsp_err;
    end
  end

  // Count of instructions accepted by decode; wraps naturally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_count <= '0;
    end else if (inst_hs) begin
      fetch_count <= fetch_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_ysyx_25020047_ifu.sv
// Bench for ysyx_25020047_ifu: transaction-level model plus directed fetch scenarios.
module tb_ysyx_25020047_ifu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid = 1'b0;
  logic [31:0] mem_rsp_data = 32'h0;
  logic        mem_rsp_err = 1'b0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst;
  logic [31:0] pc;
  logic [31:0] snpc;
  logic        fault;
  logic        npc_valid = 1'b0;
  logic [31:0] dnpc = 32'h0;
  logic [31:0] fetch_count;

  int errors = 0;
  int checks = 0;
  int req_hs_cnt = 0;
  int exp_count = 0;

  ysyx_25020047_ifu dut (
    .clk           (clk),
    .rst           (rst),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_addr  (mem_req_addr),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data),
    .mem_rsp_err   (mem_rsp_err),
    .inst_valid    (inst_valid),
    .inst_ready    (inst_ready),
    .inst          (inst),
    .pc            (pc),
    .snpc          (snpc),
    .fault         (fault),
    .npc_valid     (npc_valid),
    .dnpc          (dnpc),
    .fetch_count   (fetch_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Transaction model: a request in flight owns the next response; a delivered
  // instruction owns the next npc; misaligned npc yields a fault word.
  logic [31:0] m_pc;
  logic [31:0] m_inst;
  logic        m_fault;
  logic [31:0] m_count;
  logic        m_outstanding;
  logic        m_await_npc;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_pc          <= 32'h8000_0000;
      m_inst        <= 32'h0;
      m_fault       <= 1'b0;
      m_count       <= 32'h0;
      m_outstanding <= 1'b0;
      m_await_npc   <= 1'b0;
    end else begin
      if (mem_req_valid && mem_req_ready) m_outstanding <= 1'b1;
      if (m_outstanding && mem_rsp_valid) begin
        m_inst        <= mem_rsp_err ? 32'h0 : mem_rsp_data;
        m_fault       <= mem_rsp_err;
        m_outstanding <= 1'b0;
      end
      if (inst_valid && inst_ready) begin
        m_count     <= m_count + 32'd1;
        m_await_npc <= 1'b1;
      end
      if (m_await_npc && npc_valid) begin
        m_pc        <= dnpc;
        m_await_npc <= 1'b0;
        if (dnpc[1:0] != 2'b00) begin
          m_inst  <= 32'h0;
          m_fault <= 1'b1;
        end
      end
      if (mem_req_valid && mem_req_ready) req_hs_cnt++;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    chk("cmp_pc", pc, m_pc);
    chk("cmp_snpc", snpc, m_pc + 32'd4);
    chk("cmp_addr", mem_req_addr, m_pc);
    chk("cmp_count", fetch_count, m_count);
    if (!rst) begin
      chk("cmp_rst_vld", inst_valid, 1'b0);
      chk("cmp_rst_req", mem_req_valid, 1'b0);
      chk("cmp_rst_inst", inst, 32'h0);
      chk("cmp_rst_fault", fault, 1'b0);
    end else begin
      if (inst_valid) begin
        chk("cmp_inst", inst, m_inst);
        chk("cmp_fault", fault, m_fault);
      end
      if (m_outstanding || m_await_npc) begin
        chk("cmp_idle_req", mem_req_valid, 1'b0);
        chk("cmp_idle_vld", inst_valid, 1'b0);
      end
    end
  end

  // Starting in FETCH with an aligned PC: request, optional stall/noise, response.
  task automatic serve(input logic [31:0] addr, input int rdy_dly, input logic [31:0] data,
                       input logic err, input logic noise);
    int hs0;
    hs0 = req_hs_cnt;
    chk("fetch_no_vld", inst_valid, 1'b0);
    for (int i = 0; i < rdy_dly; i++) begin
      chk("req_held_vld", mem_req_valid, 1'b1);
      chk("req_held_addr", mem_req_addr, addr);
      tick();
    end
    chk("req_vld", mem_req_valid, 1'b1);
    chk("req_addr", mem_req_addr, addr);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    chk("one_req_hs", req_hs_cnt - hs0, 1);
    chk("wait_no_req", mem_req_valid, 1'b0);
    chk("wait_no_vld", inst_valid, 1'b0);
    if (noise) begin
      npc_valid = 1'b1;
      dnpc      = 32'h1234_5678;
      tick();
      npc_valid = 1'b0;
      chk("wait_npc_ignored_vld", inst_valid, 1'b0);
      chk("wait_npc_ignored_pc", pc, addr);
    end
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = data;
    mem_rsp_err   = err;
    tick();
    mem_rsp_valid = 1'b0;
    mem_rsp_err   = 1'b0;
  endtask

  // In DELIVER: hold decode off for acc_dly cycles, then accept.
  task automatic deliver(input int acc_dly, input logic noise);
    chk("deliver_vld", inst_valid, 1'b1);
    for (int i = 0; i < acc_dly; i++) begin
      if (noise) begin
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'h0BAD_0BAD;
      end
      tick();
      chk("bp_vld", inst_valid, 1'b1);
      chk("bp_count", fetch_count, exp_count);
    end
    mem_rsp_valid = 1'b0;
    inst_ready    = 1'b1;
    tick();
    inst_ready = 1'b0;
    exp_count++;
    chk("accept_count", fetch_count, exp_count);
    chk("next_no_vld", inst_valid, 1'b0);
  endtask

  // In NEXT: optional spurious response, then supply dnpc.
  task automatic npc(input logic [31:0] d, input logic noise);
    if (noise) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = 32'hDEAD_BEEF;
      tick();
      mem_rsp_valid = 1'b0;
      chk("next_rsp_ignored_vld", inst_valid, 1'b0);
      chk("next_rsp_ignored_req", mem_req_valid, 1'b0);
    end
    npc_valid = 1'b1;
    dnpc      = d;
    tick();
    npc_valid = 1'b0;
    chk("npc_pc", pc, d);
    chk("npc_snpc", snpc, d + 32'd4);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs0;
    #1 rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    chk("idle_no_req", mem_req_valid, 1'b0);
    tick();
    // First fetch from reset PC.
    serve(32'h8000_0000, 0, 32'h0000_0513, 1'b0, 1'b0);
    chk("first_inst", inst, 32'h0000_0513);
    chk("first_pc", pc, 32'h8000_0000);
    chk("first_snpc", snpc, 32'h8000_0004);
    chk("first_fault", fault, 1'b0);
    deliver(0, 1'b0);

    // Request stall and decode backpressure with spurious responses.
    npc(32'h8000_0004, 1'b0);
    serve(32'h8000_0004, 3, 32'h0010_0093, 1'b0, 1'b0);
    chk("bp_inst", inst, 32'h0010_0093);
    deliver(5, 1'b1);
    chk("bp_total", fetch_count, 32'd2);

    // Misaligned PC: no request, fault delivered.
    npc(32'h8000_0102, 1'b1);
    hs0 = req_hs_cnt;
    chk("mis_no_req", mem_req_valid, 1'b0);
    tick();
    chk("mis_no_hs", req_hs_cnt - hs0, 0);
    chk("mis_vld", inst_valid, 1'b1);
    chk("mis_inst", inst, 32'h0);
    chk("mis_fault", fault, 1'b1);
    chk("mis_pc", pc, 32'h8000_0102);
    deliver(0, 1'b0);

    // Bus error response.
    npc(32'h8000_0008, 1'b0);
    serve(32'h8000_0008, 0, 32'hFFFF_FFFF, 1'b1, 1'b0);
    chk("err_inst", inst, 32'h0);
    chk("err_fault", fault, 1'b1);
    deliver(0, 1'b0);

    // PC wrap and npc ignored in WAIT.
    npc(32'hFFFF_FFFC, 1'b0);
    chk("wrap_snpc", snpc, 32'h0000_0000);
    serve(32'hFFFF_FFFC, 1, 32'h0000_0073, 1'b0, 1'b1);
    chk("wrap_inst", inst, 32'h0000_0073);
    chk("wrap_fault", fault, 1'b0);
    deliver(2, 1'b0);
    chk("pre_rst_count", fetch_count, 32'd5);

    // Reset asserted while waiting for a response.
    npc(32'h8000_0010, 1'b0);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("arst_vld", inst_valid, 1'b0);
    chk("arst_req", mem_req_valid, 1'b0);
    chk("arst_pc", pc, 32'h8000_0000);
    chk("arst_snpc", snpc, 32'h8000_0004);
    chk("arst_count", fetch_count, 32'd0);
    exp_count = 0;
    @(posedge clk);
    #1 rst = 1'b1;
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 32'hCAFE_F00D;
    tick();
    mem_rsp_valid = 1'b0;
    serve(32'h8000_0000, 0, 32'h0000_0297, 1'b0, 1'b0);
    chk("post_rst_inst", inst, 32'h0000_0297);
    deliver(1, 1'b0);
    chk("post_rst_count", fetch_count, 32'd1);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
